// File: rtl/tt_trace_pkg.sv
// tt_trace_pkg: capture FSM encoding and pointer-width helper shared by the trace capture files.
package tt_trace_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArmed = 2'd1,
      StPost  = 2'd2,
      StRead  = 2'd3
   } trace_state_e;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/tt_trace_mem.sv
// tt_trace_mem: Depth x Width flop array, one synchronous write port, one asynchronous read port.
module tt_trace_mem
   import tt_trace_pkg::*;
#(
   parameter int unsigned Width = 24,
   parameter int unsigned Depth = 16,
   localparam int unsigned AddrW = ptr_w(Depth)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem_q [Depth];

   // No reset: entries are always written in the current capture before being read.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tt_trace_capture.sv
// tt_trace_capture: circular trace buffer with masked trigger, pre-trigger history and a
// valid/ready readout. Define TRACE_TIMESTAMP_EN to store a free-running timestamp per entry.
module tt_trace_capture
   import tt_trace_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned CHANNELS = 3,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned PRE_TRIG = 4,
   parameter int unsigned TS_W     = 8,
   localparam int unsigned SAMPLE_W = CHANNELS * DATA_W,
`ifdef TRACE_TIMESTAMP_EN
   localparam int unsigned ENTRY_W = SAMPLE_W + TS_W
`else
   localparam int unsigned ENTRY_W = SAMPLE_W + 0 * TS_W
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [SAMPLE_W-1:0] ch_in,
   input  logic                arm,
   input  logic                abort,
   input  logic [SAMPLE_W-1:0] trig_value,
   input  logic [SAMPLE_W-1:0] trig_mask,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [ENTRY_W-1:0]  rd_data,
   output logic                rd_last,
   output logic [1:0]          state_o,
   output logic                triggered
);

   localparam int unsigned     PtrW     = ptr_w(DEPTH);
   localparam logic [PtrW:0]   FillMax  = (PtrW + 1)'(DEPTH);
   localparam logic [PtrW:0]   FillPre  = (PtrW + 1)'(PRE_TRIG);
   localparam logic [PtrW-1:0] PostInit = PtrW'(DEPTH - PRE_TRIG - 1);
   localparam logic [PtrW-1:0] LastIdx  = PtrW'(DEPTH - 1);

   trace_state_e       state_q;
   logic [PtrW-1:0]    wr_ptr_q;
   logic [PtrW-1:0]    rd_ptr_q;
   logic [PtrW-1:0]    post_cnt_q;
   logic [PtrW-1:0]    rd_cnt_q;
   logic [PtrW:0]      fill_q;
   logic               triggered_q;
   logic               match;
   logic               mem_we;
   logic [ENTRY_W-1:0] wr_entry;

   assign match  = ((ch_in ^ trig_value) & trig_mask) == '0;
   // POST with post_cnt==0 moves to READ instead of writing.
   assign mem_we = rst_n && !abort && ena &&
                   ((state_q == StArmed) || ((state_q == StPost) && (post_cnt_q != '0)));

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + 1'b1;
      end
   end

   assign wr_entry = {ts_q, ch_in};
`else
   assign wr_entry = ch_in;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         post_cnt_q  <= '0;
         rd_cnt_q    <= '0;
         fill_q      <= '0;
         triggered_q <= 1'b0;
      end else if (abort) begin
         state_q     <= StIdle;
         triggered_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (arm) begin
                  state_q     <= StArmed;
                  wr_ptr_q    <= '0;
                  fill_q      <= '0;
                  triggered_q <= 1'b0;
               end
            end
            StArmed: begin
               if (ena) begin
                  wr_ptr_q <= wr_ptr_q + 1'b1;
                  if (fill_q != FillMax) begin
                     fill_q <= fill_q + 1'b1;
                  end
                  // fill_q is the count before this write, so PRE_TRIG history is guaranteed.
                  if (match && (fill_q >= FillPre)) begin
                     state_q     <= StPost;
                     triggered_q <= 1'b1;
                     post_cnt_q  <= PostInit;
                  end
               end
            end
            StPost: begin
               if (ena) begin
                  if (post_cnt_q == '0) begin
                     state_q  <= StRead;
                     rd_ptr_q <= wr_ptr_q;
                     rd_cnt_q <= '0;
                  end else begin
                     wr_ptr_q   <= wr_ptr_q + 1'b1;
                     post_cnt_q <= post_cnt_q - 1'b1;
                  end
               end
            end
            StRead: begin
               if (rd_ready) begin
                  rd_ptr_q <= rd_ptr_q + 1'b1;
                  rd_cnt_q <= rd_cnt_q + 1'b1;
                  if (rd_cnt_q == LastIdx) begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rd_valid  = (state_q == StRead);
   assign rd_last   = rd_valid && (rd_cnt_q == LastIdx);
   assign state_o   = state_q;
   assign triggered = triggered_q;

   tt_trace_mem #(
      .Width(ENTRY_W),
      .Depth(DEPTH)
   ) u_mem (
      .clk_i  (clk),
      .we_i   (mem_we),
      .waddr_i(wr_ptr_q),
      .wdata_i(wr_entry),
      .raddr_i(rd_ptr_q),
      .rdata_o(rd_data)
   );

endmodule

// File: tb/tb_tt_trace_capture.sv
// tb_tt_trace_capture: directed bench for tt_trace_capture (default instance plus a PRE_TRIG=0
// instance); timestamp checks are compiled in only with TRACE_TIMESTAMP_EN.
`timescale 1ns/1ps
module tb_tt_trace_capture;

   localparam int unsigned SW = 24;
`ifdef TRACE_TIMESTAMP_EN
   localparam int unsigned EW = SW + 8;
`else
   localparam int unsigned EW = SW;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b0, ena = 1'b0, arm = 1'b0, arm1 = 1'b0, abort = 1'b0;
   logic          rd_ready = 1'b0;
   logic [SW-1:0] ch_in = '0, trig_value = '0, trig_mask = '0;
   logic [SW-1:0] trig_mask1 = '0;
   logic          rd_valid0, rd_last0, triggered0, rd_valid1, rd_last1, triggered1;
   logic [EW-1:0] rd_data0, rd_data1;
   logic [1:0]    state0, state1;

   int            n_checks = 0;
   int            n_fail = 0;
   int            hit_a = -1, hit_b = -1;
   logic [7:0]    hit_val = 8'h00;
   logic [EW-1:0] rd_q[$];
   int            last_idx;

   tt_trace_capture dut0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ch_in(ch_in), .arm(arm), .abort(abort),
      .trig_value(trig_value), .trig_mask(trig_mask), .rd_valid(rd_valid0),
      .rd_ready(rd_ready), .rd_data(rd_data0), .rd_last(rd_last0), .state_o(state0),
      .triggered(triggered0)
   );

   tt_trace_capture #(.PRE_TRIG(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ch_in(ch_in), .arm(arm1), .abort(abort),
      .trig_value(trig_value), .trig_mask(trig_mask1), .rd_valid(rd_valid1),
      .rd_ready(rd_ready), .rd_data(rd_data1), .rd_last(rd_last1), .state_o(state1),
      .triggered(triggered1)
   );

   function automatic logic [SW-1:0] samp(input int i);
      logic [7:0] b  = 8'(i);
      logic [7:0] c0 = (i == hit_a || i == hit_b) ? hit_val : b;
      return {~b, b + 8'h80, c0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input bit which, input int first, output int last, output int trig_at);
      last    = -1;
      trig_at = -1;
      for (int i = first; i < first + 60; i++) begin
         ch_in = samp(i);
         ena   = 1'b1;
         step();
         if (trig_at < 0 && (which ? triggered1 : triggered0)) trig_at = i;
         if ((which ? state1 : state0) == 2'd3) begin
            last = i;
            break;
         end
      end
      ena = 1'b0;
   endtask

   task automatic drain(input bit which);
      rd_q.delete();
      last_idx = -1;
      for (int c = 0; c < 100; c++) begin
         if (!(which ? rd_valid1 : rd_valid0)) break;
         rd_ready = 1'b1;
         rd_q.push_back(which ? rd_data1 : rd_data0);
         if (which ? rd_last1 : rd_last0) last_idx = rd_q.size() - 1;
         step();
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      n_checks++; if (state0 !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state0); end
      n_checks++; if (rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid0); end
      n_checks++; if (rd_last0 !== 1'b0) begin n_fail++; $display("FAIL reset_rd_last: got %b expected 0", rd_last0); end
      n_checks++; if (triggered0 !== 1'b0) begin n_fail++; $display("FAIL reset_triggered: got %b expected 0", triggered0); end
      n_checks++; if (state1 !== 2'd0) begin n_fail++; $display("FAIL reset_state1: got %0d expected 0", state1); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int last, trig_at;
      logic [EW-1:0] ent;
      trig_value = 24'h00000A;
      trig_mask  = 24'h0000FF;
      hit_a = -1;
      hit_b = -1;
      arm = 1'b1;
      step();
      arm = 1'b0;
      n_checks++; if (state0 !== 2'd1) begin n_fail++; $display("FAIL basic_armed: got %0d expected 1", state0); end
      capture(1'b0, 0, last, trig_at);
      n_checks++; if (trig_at !== 10) begin n_fail++; $display("FAIL basic_trig_at: got %0d expected 10", trig_at); end
      n_checks++; if (last !== 22) begin n_fail++; $display("FAIL basic_read_at: got %0d expected 22", last); end
      drain(1'b0);
      n_checks++; if (rd_q.size() !== 16) begin n_fail++; $display("FAIL basic_count: got %0d expected 16", rd_q.size()); end
      for (int e = 0; e < 16; e++) begin
         ent = rd_q[e];
         n_checks++;
         if (ent[SW-1:0] !== samp(6 + e)) begin
            n_fail++; $display("FAIL basic_entry%0d: got %h expected %h", e, ent[SW-1:0], samp(6 + e));
         end
      end
      ent = rd_q[4];
      n_checks++; if (ent[7:0] !== 8'h0A) begin n_fail++; $display("FAIL basic_trig_entry: got %h expected 0a", ent[7:0]); end
      n_checks++; if (last_idx !== 15) begin n_fail++; $display("FAIL basic_last_idx: got %0d expected 15", last_idx); end
      n_checks++; if (state0 !== 2'd0) begin n_fail++; $display("FAIL basic_idle_after: got %0d expected 0", state0); end
      n_checks++; if (rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL basic_valid_after: got %b expected 0", rd_valid0); end
   endtask

   task automatic test_early_match();
      int last, trig_at;
      logic [EW-1:0] ent;
      trig_value = 24'h0000EE;
      trig_mask  = 24'h0000FF;
      hit_a = 2;
      hit_b = 20;
      hit_val = 8'hEE;
      arm = 1'b1;
      step();
      arm = 1'b0;
      capture(1'b0, 0, last, trig_at);
      n_checks++; if (trig_at !== 20) begin n_fail++; $display("FAIL early_trig_at: got %0d expected 20", trig_at); end
      n_checks++; if (last !== 32) begin n_fail++; $display("FAIL early_read_at: got %0d expected 32", last); end
      drain(1'b0);
      n_checks++; if (rd_q.size() !== 16) begin n_fail++; $display("FAIL early_count: got %0d expected 16", rd_q.size()); end
      for (int e = 0; e < 16; e++) begin
         ent = rd_q[e];
         n_checks++;
         if (ent[SW-1:0] !== samp(16 + e)) begin
            n_fail++; $display("FAIL early_entry%0d: got %h expected %h", e, ent[SW-1:0], samp(16 + e));
         end
      end
      hit_a = -1;
      hit_b = -1;
   endtask

   task automatic test_ena_gap();
      int last, trig_at;
      logic [EW-1:0] ent;
`ifdef TRACE_TIMESTAMP_EN
      logic [EW-1:0] ent_b;
      logic [7:0]    dts;
`endif
      trig_value = 24'h00000A;
      trig_mask  = 24'h0000FF;
      arm = 1'b1;
      step();
      arm = 1'b0;
      for (int i = 0; i < 14; i++) begin
         ch_in = samp(i);
         ena   = 1'b1;
         step();
      end
      n_checks++; if (state0 !== 2'd2) begin n_fail++; $display("FAIL gap_in_post: got %0d expected 2", state0); end
      for (int k = 0; k < 3; k++) begin
         ch_in = 24'hDEAD00 + 24'(k);
         ena   = 1'b0;
         step();
      end
      n_checks++; if (state0 !== 2'd2) begin n_fail++; $display("FAIL gap_hold_post: got %0d expected 2", state0); end
      capture(1'b0, 14, last, trig_at);
      n_checks++; if (last !== 22) begin n_fail++; $display("FAIL gap_read_at: got %0d expected 22", last); end
      drain(1'b0);
      n_checks++; if (rd_q.size() !== 16) begin n_fail++; $display("FAIL gap_count: got %0d expected 16", rd_q.size()); end
      for (int e = 0; e < 16; e++) begin
         ent = rd_q[e];
         n_checks++;
         if (ent[SW-1:0] !== samp(6 + e)) begin
            n_fail++; $display("FAIL gap_entry%0d: got %h expected %h", e, ent[SW-1:0], samp(6 + e));
         end
      end
`ifdef TRACE_TIMESTAMP_EN
      ent   = rd_q[6];
      ent_b = rd_q[7];
      dts   = ent_b[EW-1:SW] - ent[EW-1:SW];
      n_checks++; if (dts !== 8'd1) begin n_fail++; $display("FAIL gap_ts_step: got %0d expected 1", dts); end
      ent   = rd_q[8];
      dts   = ent[EW-1:SW] - ent_b[EW-1:SW];
      n_checks++; if (dts !== 8'd4) begin n_fail++; $display("FAIL gap_ts_jump: got %0d expected 4", dts); end
`endif
   endtask

   task automatic test_stall();
      int last, trig_at, acc;
      bit held_v;
      logic [EW-1:0] held;
      trig_value = 24'h00000A;
      trig_mask  = 24'h0000FF;
      arm = 1'b1;
      step();
      arm = 1'b0;
      capture(1'b0, 0, last, trig_at);
      acc    = 0;
      held_v = 1'b0;
      held   = '0;
      for (int c = 0; c < 100; c++) begin
         if (!rd_valid0) break;
         if (held_v) begin
            n_checks++;
            if (rd_data0 !== held) begin n_fail++; $display("FAIL stall_stable%0d: got %h expected %h", c, rd_data0, held); end
         end
         rd_ready = c[0];
         if (rd_ready) begin
            n_checks++;
            if (rd_data0[SW-1:0] !== samp(6 + acc)) begin
               n_fail++; $display("FAIL stall_entry%0d: got %h expected %h", acc, rd_data0[SW-1:0], samp(6 + acc));
            end
            n_checks++;
            if (rd_last0 !== (acc == 15)) begin n_fail++; $display("FAIL stall_last%0d: got %b expected %b", acc, rd_last0, acc == 15); end
            acc++;
            held_v = 1'b0;
         end else begin
            held   = rd_data0;
            held_v = 1'b1;
         end
         step();
      end
      rd_ready = 1'b0;
      n_checks++; if (acc !== 16) begin n_fail++; $display("FAIL stall_count: got %0d expected 16", acc); end
      n_checks++; if (state0 !== 2'd0) begin n_fail++; $display("FAIL stall_idle_after: got %0d expected 0", state0); end
   endtask

   task automatic test_abort_reset();
      int last, trig_at;
      trig_value = 24'h00000A;
      trig_mask  = 24'h0000FF;
      arm   = 1'b1;
      abort = 1'b1;
      step();
      arm   = 1'b0;
      abort = 1'b0;
      n_checks++; if (state0 !== 2'd0) begin n_fail++; $display("FAIL abort_beats_arm: got %0d expected 0", state0); end
      arm = 1'b1;
      step();
      arm = 1'b0;
      for (int i = 0; i < 13; i++) begin
         ch_in = samp(i);
         ena   = 1'b1;
         step();
      end
      n_checks++; if (state0 !== 2'd2) begin n_fail++; $display("FAIL abort_pre_post: got %0d expected 2", state0); end
      abort = 1'b1;
      step();
      abort = 1'b0;
      ena   = 1'b0;
      n_checks++; if (state0 !== 2'd0) begin n_fail++; $display("FAIL abort_state: got %0d expected 0", state0); end
      n_checks++; if (rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", rd_valid0); end
      n_checks++; if (triggered0 !== 1'b0) begin n_fail++; $display("FAIL abort_triggered: got %b expected 0", triggered0); end
      arm = 1'b1;
      step();
      arm = 1'b0;
      capture(1'b0, 0, last, trig_at);
      rd_ready = 1'b1;
      repeat (5) step();
      n_checks++; if (rd_data0[SW-1:0] !== samp(11)) begin n_fail++; $display("FAIL rst_mid_entry5: got %h expected %h", rd_data0[SW-1:0], samp(11)); end
      rst_n = 1'b0;
      step();
      n_checks++; if (state0 !== 2'd0) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected 0", state0); end
      n_checks++; if (rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", rd_valid0); end
      n_checks++; if (rd_last0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_last: got %b expected 0", rd_last0); end
      n_checks++; if (triggered0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_triggered: got %b expected 0", triggered0); end
      rst_n    = 1'b1;
      rd_ready = 1'b0;
      step();
   endtask

   task automatic test_pre_zero();
      int last, trig_at;
      logic [EW-1:0] ent;
      arm1 = 1'b1;
      step();
      arm1 = 1'b0;
      n_checks++; if (state1 !== 2'd1) begin n_fail++; $display("FAIL pre0_armed: got %0d expected 1", state1); end
      capture(1'b1, 50, last, trig_at);
      n_checks++; if (trig_at !== 50) begin n_fail++; $display("FAIL pre0_trig_at: got %0d expected 50", trig_at); end
      n_checks++; if (last !== 66) begin n_fail++; $display("FAIL pre0_read_at: got %0d expected 66", last); end
      drain(1'b1);
      n_checks++; if (rd_q.size() !== 16) begin n_fail++; $display("FAIL pre0_count: got %0d expected 16", rd_q.size()); end
      for (int e = 0; e < 16; e++) begin
         ent = rd_q[e];
         n_checks++;
         if (ent[SW-1:0] !== samp(50 + e)) begin
            n_fail++; $display("FAIL pre0_entry%0d: got %h expected %h", e, ent[SW-1:0], samp(50 + e));
         end
      end
      n_checks++; if (last_idx !== 15) begin n_fail++; $display("FAIL pre0_last_idx: got %0d expected 15", last_idx); end
      n_checks++; if (state1 !== 2'd0) begin n_fail++; $display("FAIL pre0_idle_after: got %0d expected 0", state1); end
   endtask

   initial begin
      #1;
      test_reset();
      test_basic();
      test_early_match();
      test_ena_gap();
      test_stall();
      test_abort_reset();
      test_pre_zero();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
